// File: rtl/mux4_rr_arbiter.sv
// mux4_rr_arbiter: round-robin arbiter that drives the 2-bit select of a
// shared 4:1 single-bit multiplexer, plus a one-hot grant and a valid flag.
// Optional feature: define MUX4_ARB_TIMEOUT_EN to limit how long one owner
// may hold the grant (MAX_HOLD consecutive cycles).
// All outputs are registered; reset is asynchronous and active low.
module mux4_rr_arbiter #(
    parameter int MAX_HOLD = 8
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [3:0] req,
    output logic [3:0] gnt,
    output logic [1:0] s,
    output logic       valid
);

    typedef enum logic {
        IDLE = 1'b0,
        OWN  = 1'b1
    } state_t;

    state_t     state;
    logic [1:0] own;
    logic [1:0] ptr;

    logic       timeout;
    logic       rel;
    logic [3:0] own_mask;
    logic [3:0] others;
    logic [3:0] cand;
    logic       win_found;
    logic [1:0] win;

`ifdef MUX4_ARB_TIMEOUT_EN
    logic [7:0] hold_cnt;
    localparam logic [7:0] HOLD_LAST = 8'(MAX_HOLD - 1);

    // Timeout fires on the last allowed cycle while the owner still requests
    assign timeout = (state == OWN) && (hold_cnt == HOLD_LAST) && req[own];
`else
    logic unused_max_hold;

    // Without the timeout feature the hold limit plays no part
    assign unused_max_hold = (MAX_HOLD > 0);
    assign timeout         = 1'b0;
`endif

    assign own_mask = 4'b0001 << own;
    assign others   = req & ~own_mask;
    assign rel      = (state == OWN) && (!req[own] || timeout);

    // Candidate set: old owner only competes on timeout when nobody else asks
    always_comb begin
        cand = req;
        if (state == OWN && timeout) begin
            cand = (others != 4'b0000) ? others : req;
        end
    end

    // Pick the first candidate in search order ptr, ptr+1, ptr+2, ptr+3
    always_comb begin
        logic [1:0] idx;
        win_found = 1'b0;
        win       = ptr;
        idx       = ptr;
        for (int k = 3; k >= 0; k--) begin
            idx = ptr + 2'(k);
            if (cand[idx]) begin
                win_found = 1'b1;
                win       = idx;
            end
        end
    end

    // Arbitration state machine with registered grant, select and valid
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
            own   <= 2'd0;
            ptr   <= 2'd0;
            gnt   <= 4'b0000;
            s     <= 2'b00;
            valid <= 1'b0;
`ifdef MUX4_ARB_TIMEOUT_EN
            hold_cnt <= 8'd0;
`endif
        end else begin
            if ((state == IDLE) || rel) begin
                if (win_found) begin
                    state <= OWN;
                    own   <= win;
                    ptr   <= win + 2'd1;
                    gnt   <= 4'b0001 << win;
                    s     <= win;
                    valid <= 1'b1;
`ifdef MUX4_ARB_TIMEOUT_EN
                    hold_cnt <= 8'd0;
`endif
                end else begin
                    // No requester: drop the grant, keep the last select
                    state <= IDLE;
                    gnt   <= 4'b0000;
                    valid <= 1'b0;
                end
            end else begin
                // Owner keeps the grant; count consecutive held cycles
`ifdef MUX4_ARB_TIMEOUT_EN
                if (hold_cnt < HOLD_LAST) begin
                    hold_cnt <= hold_cnt + 8'd1;
                end
`endif
                state <= OWN;
            end
        end
    end

endmodule

// File: tb/tb_mux4_rr_arbiter.sv
// Directed testbench for mux4_rr_arbiter (MAX_HOLD = 4).
module tb_mux4_rr_arbiter;

    logic       clk;
    logic       rst_n;
    logic [3:0] req;
    logic [3:0] gnt;
    logic [1:0] s;
    logic       valid;

    int errors = 0;
    int checks = 0;

    mux4_rr_arbiter #(.MAX_HOLD(4)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .req   (req),
        .gnt   (gnt),
        .s     (s),
        .valid (valid)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [3:0] obs, input logic [3:0] exp_v);
        checks++;
        assert (obs === exp_v) else begin
            errors++;
            $error("FAIL %s: observed=%b expected=%b", tag, obs, exp_v);
        end
    endtask

    // Check all three outputs of one cycle and print a transaction line
    task automatic chk_out(input string tag, input logic [3:0] eg, input logic [1:0] es, input logic ev);
        $display("%0t %s req=%b gnt=%b s=%b valid=%b", $time, tag, req, gnt, s, valid);
        chk({tag, ".gnt"}, gnt, eg);
        chk({tag, ".s"}, {2'b00, s}, {2'b00, es});
        chk({tag, ".valid"}, {3'b000, valid}, {3'b000, ev});
    endtask

    // Advance one clock edge and settle away from it
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    initial begin
        // Reset with all requests high
        rst_n = 1'b0;
        req   = 4'b1111;
        repeat (3) step();
        chk_out("reset", 4'b0000, 2'b00, 1'b0);
        rst_n = 1'b1;
        step();
        chk_out("post_reset", 4'b0001, 2'b00, 1'b1);

        // Back to IDLE, then single requester
        req = 4'b0000;
        step();
        chk_out("idle1", 4'b0000, 2'b00, 1'b0);
        req = 4'b0100;
        step();
        chk_out("single_grant", 4'b0100, 2'b10, 1'b1);
        req = 4'b0000;
        step();
        chk_out("single_drop", 4'b0000, 2'b10, 1'b0);

        // Rotation 0,1,2,3,0 with no idle cycle
        req = 4'b0001;
        step();
        chk_out("rot0", 4'b0001, 2'b00, 1'b1);
        req = 4'b1110;
        step();
        chk_out("rot1", 4'b0010, 2'b01, 1'b1);
        req = 4'b1101;
        step();
        chk_out("rot2", 4'b0100, 2'b10, 1'b1);
        req = 4'b1011;
        step();
        chk_out("rot3", 4'b1000, 2'b11, 1'b1);
        req = 4'b0111;
        step();
        chk_out("rot0b", 4'b0001, 2'b00, 1'b1);

        // Pointer order: ptr=2, req=1011 -> grant index 3
        req = 4'b0010;
        step();
        chk_out("to1", 4'b0010, 2'b01, 1'b1);
        req = 4'b0000;
        step();
        chk_out("idle2", 4'b0000, 2'b01, 1'b0);
        req = 4'b1011;
        step();
        chk_out("ptr2_pick3", 4'b1000, 2'b11, 1'b1);

        // ptr is now 0: req=0011 -> owner 0
        req = 4'b0011;
`ifdef MUX4_ARB_TIMEOUT_EN
        for (int i = 0; i < 16; i++) begin
            step();
            if (((i / 4) % 2) == 0)
                chk_out($sformatf("tmo_%0d", i), 4'b0001, 2'b00, 1'b1);
            else
                chk_out($sformatf("tmo_%0d", i), 4'b0010, 2'b01, 1'b1);
        end
        req = 4'b0001;
        for (int i = 0; i < 10; i++) begin
            step();
            chk_out($sformatf("solo_%0d", i), 4'b0001, 2'b00, 1'b1);
        end
`else
        for (int i = 0; i < 20; i++) begin
            step();
            chk_out($sformatf("notmo_%0d", i), 4'b0001, 2'b00, 1'b1);
        end
`endif

        // Reset mid-grant while gnt=1000
        req = 4'b1000;
        step();
        chk_out("pre_rst", 4'b1000, 2'b11, 1'b1);
        req = 4'b1111;
        #2;
        rst_n = 1'b0;
        #1;
        chk_out("async_rst", 4'b0000, 2'b00, 1'b0);
        #1;
        rst_n = 1'b1;
        step();
        chk_out("resume", 4'b0001, 2'b00, 1'b1);

        req = 4'b0000;
        step();
        chk_out("final_idle", 4'b0000, 2'b00, 1'b0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
